// File: rtl/mac32_dot_seq.sv
// Sequencer folding (a,b) pairs into an accumulator through an external MAC32_top.
// Optional sticky NaN flag: define MAC32_DOT_SEQ_NAN_FLAG_EN.
module mac32_dot_seq #(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [PARM_LEN_W-1:0] len_i,
  input  logic [PARM_XLEN-1:0]  init_c_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PARM_XLEN-1:0]  a_i,
  input  logic [PARM_XLEN-1:0]  b_i,
  output logic [PARM_XLEN-1:0]  mac_a_o,
  output logic [PARM_XLEN-1:0]  mac_b_o,
  output logic [PARM_XLEN-1:0]  mac_c_o,
  input  logic [PARM_XLEN-1:0]  mac_result_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PARM_XLEN-1:0]  sum_o,
  output logic                  busy_o,
  output logic                  nan_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PARM_XLEN-1:0]    acc_q, op_a_q, op_b_q;
  logic [PARM_LEN_W-1:0]   cnt_q;
  logic                    op_v_q;
  logic                    start_acc;
  logic                    hs;

  assign start_acc   = (state_q == S_IDLE) && start_i;
  assign in_ready_o  = (state_q == S_RUN) && (cnt_q != '0);
  assign hs          = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign sum_o       = acc_q;
  assign mac_a_o     = op_a_q;
  assign mac_b_o     = op_b_q;
  assign mac_c_o     = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (len_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // last product lands one edge after its handshake
        if (op_v_q && (cnt_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_v_q <= 1'b0;
    end else begin
      op_v_q <= hs;
      if (hs) begin
        op_a_q <= a_i;
        op_b_q <= b_i;
      end
      if (start_acc) begin
        acc_q <= init_c_i;
        cnt_q <= len_i;
      end else begin
        if (hs) begin
          cnt_q <= cnt_q - PARM_LEN_W'(1);
        end
        if (op_v_q) begin
          acc_q <= mac_result_i;
        end
      end
    end
  end

`ifdef MAC32_DOT_SEQ_NAN_FLAG_EN
  localparam int MAN_W = PARM_XLEN - 9;

  logic nan_q;
  logic res_nan;

  assign res_nan = (&mac_result_i[PARM_XLEN-2 -: 8]) &&
                   (|mac_result_i[MAN_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_q <= 1'b0;
    end else if (start_acc) begin
      nan_q <= 1'b0;
    end else if (op_v_q && res_nan) begin
      nan_q <= 1'b1;
    end
  end

  assign nan_o = nan_q;
`else
  assign nan_o = 1'b0;
`endif

endmodule

// File: tb/tb_mac32_dot_seq.sv
// Scoreboard bench for mac32_dot_seq with a behavioural FP32 MAC model.
// Expected sums are left-to-right folds computed at issue time.
module tb_mac32_dot_seq;

`ifdef MAC32_DOT_SEQ_NAN_FLAG_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [31:0] init_c;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [31:0] mac_a, mac_b, mac_c, mac_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        busy;
  logic        nan;

  typedef struct {
    logic [31:0] sum;
    logic        nan;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [31:0] pa[16];
  logic [31:0] pb[16];

  mac32_dot_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .len_i        (len),
    .init_c_i     (init_c),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_i          (a),
    .b_i          (b),
    .mac_a_o      (mac_a),
    .mac_b_o      (mac_b),
    .mac_c_o      (mac_c),
    .mac_result_i (mac_res),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .sum_o        (sum),
    .busy_o       (busy),
    .nan_o        (nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 0) return 0.0;
    e = 11'(int'(x[30:23]) + 896);
    d = {x[31], e, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [7:0]  e8;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 896;
    e8 = e[7:0];
    return {d[63], e8, d[51:29]};
  endfunction

  function automatic logic [31:0] mac_fn(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic [31:0] z);
    if (is_nan(x) || is_nan(y) || is_nan(z)) return 32'h7FC00000;
    return r2f(f2r(z) + f2r(x) * f2r(y));
  endfunction

  // external combinational MAC32_top stand-in
  always_comb mac_res = mac_fn(mac_a, mac_b, mac_c);

  function automatic logic [31:0] rnd_fp();
    int v;
    v = int'($urandom_range(0, 16)) - 8;
    return r2f(real'(v));
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got sum %h expected none", sum);
      end else begin
        if (sum !== sb[0].sum) begin
          errors++;
          $display("FAIL sum: got %h expected %h", sum, sb[0].sum);
        end
        checks++;
        if (nan !== sb[0].nan) begin
          errors++;
          $display("FAIL nan_flag: got %b expected %b", nan, sb[0].nan);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic run_seq(input int n, input logic [31:0] init,
                         input int gap, input int hold,
                         input bit poke, input int exp_lat);
    exp_t        e;
    logic [31:0] acc;
    bit          sawnan;
    int          w;
    acc    = init;
    sawnan = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = mac_fn(pa[i], pb[i], acc);
      if (is_nan(acc)) sawnan = 1'b1;
    end
    e.sum = acc;
    e.nan = NAN_EN && sawnan;
    sb.push_back(e);
    start  = 1'b1;
    len    = 8'(n);
    init_c = init;
    tick();
    start  = 1'b0;
    len    = 8'($urandom_range(1, 9));
    init_c = $urandom;
    chk("nan_after_start", {31'b0, nan}, 32'h0);
    if (n == 0) chk("ready_len0", {31'b0, in_ready}, 32'h0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a = pa[i];
      b = pb[i];
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
      tick();
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      for (int g = 0; g < gap; g++) begin
        if (poke) begin
          start = 1'b1;
          len   = 8'd2;
        end
        tick();
      end
      start = 1'b0;
    end
    w = 0;
    while (!out_valid && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("done_timeout", 32'd0, 32'd1);
    else if (exp_lat >= 0) chk("done_latency", 32'(w), 32'(exp_lat));
    for (int h = 0; h < hold; h++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_accept", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    init_c    = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_nan", {31'b0, nan}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    pa[0] = 32'h3F800000; pb[0] = 32'h40400000;
    pa[1] = 32'h40000000; pb[1] = 32'h40800000;
    run_seq(2, 32'h0, 0, 0, 1'b0, 1);

    run_seq(0, 32'h40A00000, 0, 0, 1'b0, 0);

    for (int i = 0; i < 3; i++) begin
      pa[i] = 32'h3F800000;
      pb[i] = 32'h3F800000;
    end
    run_seq(3, 32'h0, 2, 5, 1'b0, -1);

    for (int i = 0; i < 5; i++) begin
      pa[i] = rnd_fp();
      pb[i] = rnd_fp();
    end
    run_seq(5, rnd_fp(), 1, 1, 1'b1, -1);

    start  = 1'b1;
    len    = 8'd4;
    init_c = 32'h3F800000;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a        = 32'h40000000;
    b        = 32'h40000000;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, in_ready}, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_sum", sum, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    pa[0] = 32'h40000000; pb[0] = 32'h40000000;
    run_seq(1, 32'h0, 0, 0, 1'b0, 1);

    pa[0] = 32'h7FC00000; pb[0] = 32'h3F800000;
    pa[1] = 32'h3F800000; pb[1] = 32'h3F800000;
    run_seq(2, 32'h0, 0, 2, 1'b0, 1);
    pa[0] = 32'h3F800000; pb[0] = 32'h40000000;
    run_seq(1, 32'h3F800000, 0, 0, 1'b0, 1);

    for (int t = 0; t < 20; t++) begin
      int n;
      int gp;
      n  = int'($urandom_range(0, 8));
      gp = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        pa[i] = rnd_fp();
        pb[i] = rnd_fp();
      end
      run_seq(n, rnd_fp(), gp, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), (n == 0) ? 0 : ((gp == 0) ? 1 : -1));
    end

    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
